// File: rtl/cache_snoop_responder_if.sv
// Snoop bus bundle between the bus arbiter (master) and a cache responder (slave).
interface cache_snoop_responder_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              snp_req;
    logic [ADDR_W-1:0] snp_addr;
    logic              snp_type;
    logic              snp_ack;
    logic              snp_found;
    logic              snp_flush;
    logic [DATA_W-1:0] snp_data;

    modport master (
        output snp_req, snp_addr, snp_type,
        input  snp_ack, snp_found, snp_flush, snp_data
    );

    modport slave (
        input  snp_req, snp_addr, snp_type,
        output snp_ack, snp_found, snp_flush, snp_data
    );
endinterface

// File: rtl/cache_snoop_responder.sv
// MSI snoop responder with a private direct-mapped tag/state/data array.
// Define CACHE_SNOOP_STATS_EN to enable the saturating snoop hit counter.
module cache_snoop_responder #(
    parameter int ADDR_W  = 11,
    parameter int INDEX_W = 4,
    parameter int DATA_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cache_snoop_responder_if.slave snp,
    input  logic                   lcl_fill,
    input  logic                   lcl_fill_m,
    input  logic                   lcl_wr_hit,
    input  logic [ADDR_W-1:0]      lcl_addr,
    input  logic [DATA_W-1:0]      lcl_wdata,
    output logic                   lcl_busy,
    output logic [15:0]            snp_hit_cnt
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, FLUSH, RESP} fsm_t;
    typedef enum logic [1:0] {L_I, L_S, L_M} line_t;

    fsm_t              st_q, st_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              type_q, type_d;
    logic              ack_q, ack_d;
    logic              found_q, found_d;
    logic              flush_q, flush_d;
    logic [DATA_W-1:0] data_q, data_d;

    line_t             lst_q [LINES];
    line_t             lst_d [LINES];
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [TAG_W-1:0]  tag_d [LINES];
    logic [DATA_W-1:0] dat_q [LINES];
    logic [DATA_W-1:0] dat_d [LINES];

    logic [INDEX_W-1:0] s_idx, l_idx;
    logic [TAG_W-1:0]   s_tag, l_tag;
    logic               s_hit, s_m, l_hit;

    assign s_idx = addr_q[INDEX_W-1:0];
    assign s_tag = addr_q[ADDR_W-1:INDEX_W];
    assign l_idx = lcl_addr[INDEX_W-1:0];
    assign l_tag = lcl_addr[ADDR_W-1:INDEX_W];

    assign s_hit = (lst_q[s_idx] != L_I) && (tag_q[s_idx] == s_tag);
    assign s_m   = s_hit && (lst_q[s_idx] == L_M);
    assign l_hit = (lst_q[l_idx] != L_I) && (tag_q[l_idx] == l_tag);

    // The latched snoop line is frozen from LOOKUP until the update in RESP
    assign lcl_busy = (st_q != IDLE) && (lcl_fill || lcl_wr_hit) &&
                      (l_idx == s_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            addr_q  <= '0;
            type_q  <= 1'b0;
            ack_q   <= 1'b0;
            found_q <= 1'b0;
            flush_q <= 1'b0;
            data_q  <= '0;
            for (int i = 0; i < LINES; i++) lst_q[i] <= L_I;
        end else begin
            st_q    <= st_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            ack_q   <= ack_d;
            found_q <= found_d;
            flush_q <= flush_d;
            data_q  <= data_d;
            lst_q   <= lst_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        dat_q <= dat_d;
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE:    if (snp.snp_req) st_d = LOOKUP;
            LOOKUP:  st_d = s_m ? FLUSH : RESP;
            FLUSH:   st_d = RESP;
            RESP:    st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        type_d  = type_q;
        if (st_q == IDLE && snp.snp_req) begin
            addr_d = snp.snp_addr;
            type_d = snp.snp_type;
        end
        ack_d   = ((st_q == LOOKUP) && !s_m) || (st_q == FLUSH);
        found_d = ((st_q == LOOKUP) && s_hit) || (st_q == FLUSH);
        flush_d = (st_q == FLUSH);
        data_d  = (st_q == FLUSH) ? dat_q[s_idx] : data_q;
    end

    always_comb begin
        lst_d = lst_q;
        tag_d = tag_q;
        dat_d = dat_q;
        if (!lcl_busy) begin
            if (lcl_fill) begin
                tag_d[l_idx] = l_tag;
                dat_d[l_idx] = lcl_wdata;
                lst_d[l_idx] = lcl_fill_m ? L_M : L_S;
            end else if (lcl_wr_hit && l_hit) begin
                dat_d[l_idx] = lcl_wdata;
                lst_d[l_idx] = L_M;
            end
        end
        if (st_q == RESP && found_q) begin
            lst_d[s_idx] = type_q ? L_I : L_S;
        end
    end

    assign snp.snp_ack   = ack_q;
    assign snp.snp_found = found_q;
    assign snp.snp_flush = flush_q;
    assign snp.snp_data  = data_q;

`ifdef CACHE_SNOOP_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (st_q == RESP && found_q && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign snp_hit_cnt = cnt_q;
`else
    assign snp_hit_cnt = '0;
`endif
endmodule
